mcp23s17_spi_target: RTL and testbench
======================================

# mcp23s17_spi_target

Cycle-accurate FPGA-side model of an MCP23S17 16-bit SPI GPIO expander, acting as the SPI responder to our `mcp23s17_input` master. It decodes the device opcode, register-address and data-byte protocol in SPI mode 0, holds the BANK=0 register file, and drives two 8-bit ports plus the INTA line. It lets the joystick path be exercised in simulation and on boards without the physical expander.

## Interface
- `HW_ADDR`, default 3'b000: hardware address pins A2..A1..A0, compared when IOCON.HAEN=1.
- `clk`  in  1  system clock, at least 8x the SCK frequency.
- `RESET_N`  in  1  synchronous, active-low reset.
- `sck`  in  1  SPI clock, mode 0, asynchronous to `clk`.
- `mosi`  in  1  SPI data from the master.
- `cs`  in  1  chip select, active-low.
- `miso`  out  1  SPI data to the master.
- `miso_oe`  out  1  high while `miso` is driven (read phase of a matched transaction).
- `inta`  out  1  interrupt output; polarity set by IOCON.INTPOL.
- `gpa_in`, `gpb_in`  in  8 each  port pin inputs, asynchronous.
- `gpa_out`, `gpb_out`  out  8 each  OLATA / OLATB.
- `gpa_oe`, `gpb_oe`  out  8 each  ~IODIRA / ~IODIRB (1 = bit is an output).

## Operation
- **Synchronisers:** `sck`, `cs`, `mosi`, `gpa_in` and `gpb_in` each pass through two flops. SCK rise and fall events come from the synchronised `sck`.
- **Frame format**, MSB first:
  - Byte 0 is the opcode `0100_A2A1A0_RW`.
  - Byte 1 is the register address.
  - Bytes 2 and up are data.
- **Frame state machine:** IDLE, OPCODE, ADDR, DATA, IGNORE.
  - IDLE -> OPCODE on `cs` falling.
  - OPCODE -> ADDR after 8 bits if `opcode[7:4]==4'b0100` and the address matches. The address matches when HAEN=0, or when HAEN=1 and `opcode[3:1]==HW_ADDR`. Otherwise OPCODE -> IGNORE.
  - ADDR -> DATA after 8 bits.
  - DATA stays in DATA until `cs` rises.
  - Any state -> IDLE on `cs` high. This discards the partial byte and clears the bit counter.
- **Register map** (BANK=0): 0x00/01 IODIR, 0x02/03 IPOL, 0x04/05 GPINTEN, 0x06/07 DEFVAL, 0x08/09 INTCON, 0x0A/0x0B IOCON (one shared register), 0x0C/0D GPPU, 0x0E/0F INTF, 0x10/11 INTCAP, 0x12/13 GPIO, 0x14/15 OLAT.
  - Reset values: IODIR = 0xFF; every other register = 0x00.
- **Read-only registers:** INTF and INTCAP ignore writes. GPPU is storage only.
- **IOCON bits used:**
  - bit6 MIRROR
  - bit5 SEQOP
  - bit3 HAEN
  - bit1 INTPOL
  - bit7 (BANK) is stored but ignored.
- **GPIO reads** return `port ^ IPOL`. `port` is defined per bit: bits with IODIR=1 take the synchronised pin; bits with IODIR=0 take OLAT.
- **GPIO writes** update OLAT.
- **Addresses 0x16–0x1F:** reads return 0x00 and writes are ignored.
- **Write path:** a data byte commits to the addressed register on the clk cycle after its 8th SCK rise.
- **Read path:** the data byte is loaded into the MISO shifter on the SCK fall that follows the 8th bit of the previous byte (the ADDR byte or the previous data byte). Its MSB appears on `miso` at that fall.
- **Address advance:** after each data byte, the address increments when SEQOP=0 and wraps 0x15 -> 0x00. When SEQOP=1 the address is held.
- **Interrupt-on-change**, per port and per bit where GPINTEN=1:
  - The condition is `pin != prev_pin` when INTCON=0, or `pin != DEFVAL` when INTCON=1.
  - `prev_pin` is the synchronised pin value from the previous clk cycle.
  - When INTF for the port is zero and any bit fires: set those INTF bits and capture INTCAP = current synchronised port pins.
  - While INTF is nonzero, further firing bits are OR-ed into INTF and INTCAP is held.
  - Reading GPIO or INTCAP of a port clears that port's INTF when the read byte is loaded.
  - If a new event occurs in the same cycle as the clear, the set wins.
- **`inta` output:** `int_a = |INTFA`, or `|INTFA | |INTFB` when MIRROR=1. `inta = INTPOL ? int_a : ~int_a`.

## Timing
- **Reset values:**
  - `miso` = 0, `miso_oe` = 0, `inta` = 1 (INTPOL = 0).
  - `gpa_out` = `gpb_out` = 0x00.
  - `gpa_oe` = `gpb_oe` = 0x00.
  - Frame state machine in IDLE.
- **Reset mid-frame** aborts the frame. The frame resumes only after a fresh `cs` fall.
- **`miso_oe`** is high from the read-byte load until `cs` rises. It is 0 for write frames, ignored frames and `cs` high.
- **SCK-to-register latency:** 3 clk cycles from the SCK rise to the register update (2 synchroniser cycles + 1 commit cycle).
- **Pin-to-interrupt latency:** a pin change reaches `inta` in 4 clk cycles (2 synchroniser cycles + edge compare + INTF flop).
- **Output latency:** a register change reaches `gpa_out`/`gpa_oe` 1 cycle after commit.

## Test plan
- **Reset state:** assert RESET_N=0 for 4 cycles, then read 0x00 -> returns 0xFF. Read 0x0A -> returns 0x00.
- **Write and output:** write frame `40 14 A5` -> `gpa_out` = 0xA5. Then write `40 00 00` -> `gpa_oe` = 0xFF. Then read `41 12` -> `miso` bytes 0xA5.
- **Sequential write with wrap:** burst write `40 14 11 22 33` -> OLATA = 0x11, OLATB = 0x22, IODIRA = 0x33. With IOCON = 0x20 (SEQOP=1), repeated reads of 0x12 do not advance the address.
- **Hardware address matching:** HAEN=1 and HW_ADDR=3'b010. Opcode 0x44 is accepted; opcode 0x40 -> IGNORE state, `miso_oe` stays 0, no register changes.
- **Interrupt-on-change:** GPINTENA = 0x01, INTCON = 0. Toggle `gpa_in[0]` -> `inta` goes low after 4 cycles and INTCAPA captures the pin value. Read 0x12 -> `inta` returns high.
- **Abort mid-byte:** `cs` rises mid-byte during a write -> no commit. The next frame decodes its opcode correctly.

Source files
------------

// File: rtl/mcp23s17_spi_target.sv
// FPGA-side stand-in for an MCP23S17 SPI GPIO expander (BANK=0 register map, SPI mode 0).
// Frames are decoded from synchronised SCK edges; two 8-bit ports and INTA are driven from the register file.
module mcp23s17_spi_target #(
    parameter logic [2:0] HW_ADDR = 3'b000
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       sck,
    input  logic       mosi,
    input  logic       cs,
    output logic       miso,
    output logic       miso_oe,
    output logic       inta,
    input  logic [7:0] gpa_in,
    input  logic [7:0] gpb_in,
    output logic [7:0] gpa_out,
    output logic [7:0] gpb_out,
    output logic [7:0] gpa_oe,
    output logic [7:0] gpb_oe
);

    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA, IGNORE} state_e;

    state_e state_q, state_d;

    logic [1:0]      sck_sync_q, cs_sync_q, mosi_sync_q;
    logic            sck_prev_q, cs_prev_q;
    logic [1:0][7:0] pin_s1_q, pin_s2_q, pin_prev_q, cap_q;

    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       rw_q;
    logic [7:0] addr_q;
    logic       load_pend_q;
    logic [7:0] miso_sh_q;
    logic       miso_oe_q;

    logic [1:0][7:0] iodir_q, ipol_q, gpinten_q, defval_q, intcon_q, gppu_q;
    logic [1:0][7:0] intf_q, intcap_q, olat_q, fire_q;
    logic [1:0][7:0] out_q, oe_q;
    logic [7:0]      iocon_q;

    logic            sck_rise, sck_fall, cs_hi, cs_fall;
    logic [7:0]      byte_in;
    logic            byte_done, op_match, load, wr_en;
    logic [7:0]      next_addr, rdata;
    logic [1:0][7:0] port_v;
    logic [1:0]      clr;
    logic            int_a;

    // Synchronisers are free-running so a cs held low across reset is not seen as a fresh fall.
    always_ff @(posedge clk) begin
        sck_sync_q  <= {sck_sync_q[0], sck};
        cs_sync_q   <= {cs_sync_q[0], cs};
        mosi_sync_q <= {mosi_sync_q[0], mosi};
        sck_prev_q  <= sck_sync_q[1];
        cs_prev_q   <= cs_sync_q[1];
        pin_s1_q    <= {gpb_in, gpa_in};
        pin_s2_q    <= pin_s1_q;
        pin_prev_q  <= pin_s2_q;
        cap_q       <= pin_s2_q;
    end

    assign sck_rise  = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall  = ~sck_sync_q[1] & sck_prev_q;
    assign cs_hi     = cs_sync_q[1];
    assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;
    assign byte_in   = {shift_q, mosi_sync_q[1]};
    assign byte_done = sck_rise && !cs_hi && (bit_cnt_q == 3'd7) && (state_q != IDLE);
    assign op_match  = (byte_in[7:4] == 4'b0100) && (!iocon_q[3] || (byte_in[3:1] == HW_ADDR));
    assign load      = sck_fall && load_pend_q && !cs_hi;
    assign wr_en     = byte_done && (state_q == DATA) && !rw_q;
    assign next_addr = (addr_q == 8'h15) ? 8'h00 : addr_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_hi) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = OPCODE;
                OPCODE:  if (byte_done) state_d = op_match ? ADDR : IGNORE;
                ADDR:    if (byte_done) state_d = DATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sck_rise) shift_q <= byte_in[6:0];
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            bit_cnt_q   <= 3'd0;
            rw_q        <= 1'b0;
            addr_q      <= 8'h00;
            load_pend_q <= 1'b0;
            miso_sh_q   <= 8'h00;
            miso_oe_q   <= 1'b0;
        end else begin
            if (cs_hi || state_q == IDLE) bit_cnt_q <= 3'd0;
            else if (sck_rise)            bit_cnt_q <= bit_cnt_q + 3'd1;

            if (byte_done && state_q == OPCODE) rw_q <= byte_in[0];

            if (byte_done && state_q == ADDR)                        addr_q <= byte_in;
            else if (byte_done && state_q == DATA && !iocon_q[5])    addr_q <= next_addr;

            // Next read byte is fetched on the SCK fall that follows each completed byte.
            if (cs_hi)                                                          load_pend_q <= 1'b0;
            else if (byte_done && rw_q && (state_q == ADDR || state_q == DATA)) load_pend_q <= 1'b1;
            else if (load)                                                      load_pend_q <= 1'b0;

            if (cs_hi) begin
                miso_sh_q <= 8'h00;
                miso_oe_q <= 1'b0;
            end else if (load) begin
                miso_sh_q <= rdata;
                miso_oe_q <= 1'b1;
            end else if (sck_fall) begin
                miso_sh_q <= {miso_sh_q[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        port_v = '0;
        clr    = '0;
        for (int p = 0; p < 2; p++) begin
            port_v[p] = (iodir_q[p] & pin_s2_q[p]) | (~iodir_q[p] & olat_q[p]);
            clr[p]    = load && (addr_q[7:1] == 7'h08 || addr_q[7:1] == 7'h09) && (addr_q[0] == p[0]);
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr_q[7:1])
            7'h00:   rdata = iodir_q[addr_q[0]];
            7'h01:   rdata = ipol_q[addr_q[0]];
            7'h02:   rdata = gpinten_q[addr_q[0]];
            7'h03:   rdata = defval_q[addr_q[0]];
            7'h04:   rdata = intcon_q[addr_q[0]];
            7'h05:   rdata = iocon_q;
            7'h06:   rdata = gppu_q[addr_q[0]];
            7'h07:   rdata = intf_q[addr_q[0]];
            7'h08:   rdata = intcap_q[addr_q[0]];
            7'h09:   rdata = port_v[addr_q[0]] ^ ipol_q[addr_q[0]];
            7'h0A:   rdata = olat_q[addr_q[0]];
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            iodir_q   <= {2{8'hFF}};
            ipol_q    <= '0;
            gpinten_q <= '0;
            defval_q  <= '0;
            intcon_q  <= '0;
            gppu_q    <= '0;
            iocon_q   <= 8'h00;
            olat_q    <= '0;
            intf_q    <= '0;
            intcap_q  <= '0;
            fire_q    <= '0;
            out_q     <= '0;
            oe_q      <= '0;
        end else begin
            if (wr_en) begin
                case (addr_q[7:1])
                    7'h00:        iodir_q[addr_q[0]]   <= byte_in;
                    7'h01:        ipol_q[addr_q[0]]    <= byte_in;
                    7'h02:        gpinten_q[addr_q[0]] <= byte_in;
                    7'h03:        defval_q[addr_q[0]]  <= byte_in;
                    7'h04:        intcon_q[addr_q[0]]  <= byte_in;
                    7'h05:        iocon_q              <= byte_in;
                    7'h06:        gppu_q[addr_q[0]]    <= byte_in;
                    7'h09, 7'h0A: olat_q[addr_q[0]]    <= byte_in;
                    default: ;
                endcase
            end
            // Compare stage, then INTF/INTCAP; a set in the same cycle as a read-clear wins.
            for (int p = 0; p < 2; p++) begin
                fire_q[p] <= gpinten_q[p] & (intcon_q[p] ? (pin_s2_q[p] ^ defval_q[p])
                                                         : (pin_s2_q[p] ^ pin_prev_q[p]));
                if (|fire_q[p] && (intf_q[p] == 8'h00 || clr[p])) intcap_q[p] <= cap_q[p];
                if (clr[p]) intf_q[p] <= fire_q[p];
                else        intf_q[p] <= intf_q[p] | fire_q[p];
            end
            out_q <= olat_q;
            oe_q  <= ~iodir_q;
        end
    end

    assign int_a   = (|intf_q[0]) | (iocon_q[6] & (|intf_q[1]));
    assign inta    = iocon_q[1] ? int_a : ~int_a;
    assign miso    = miso_sh_q[7];
    assign miso_oe = miso_oe_q;
    assign gpa_out = out_q[0];
    assign gpb_out = out_q[1];
    assign gpa_oe  = oe_q[0];
    assign gpb_oe  = oe_q[1];

endmodule

// File: tb/tb_mcp23s17_spi_target.sv
// Directed bench for mcp23s17_spi_target: drives SPI mode-0 frames as a master and checks
// register, port, interrupt and abort behaviour against hand-computed values.
module tb_mcp23s17_spi_target;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic       sck, mosi, cs;
    logic       miso, miso_oe, inta;
    logic [7:0] gpa_in, gpb_in, gpa_out, gpb_out, gpa_oe, gpb_oe;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic       oe_seen;
    logic [7:0] v;

    mcp23s17_spi_target #(.HW_ADDR(3'b010)) dut (
        .clk(clk), .RESET_N(RESET_N), .sck(sck), .mosi(mosi), .cs(cs),
        .miso(miso), .miso_oe(miso_oe), .inta(inta),
        .gpa_in(gpa_in), .gpb_in(gpb_in),
        .gpa_out(gpa_out), .gpb_out(gpb_out), .gpa_oe(gpa_oe), .gpb_oe(gpb_oe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Master samples miso just before each rising edge; SCK half period is 6 clk cycles.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            #60;
            rx[i] = miso;
            oe_seen = oe_seen | miso_oe;
            sck = 1'b1;
            #60;
            sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n);
        logic [7:0] r;
        @(negedge clk);
        oe_seen = 1'b0;
        cs = 1'b0;
        #60;
        for (int b = 0; b < n; b++) begin
            spi_bits(tx_buf[b], 8, r);
            rx_buf[b] = r;
        end
        #60;
        cs = 1'b1;
        #120;
    endtask

    task automatic wr(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
        tx_buf[0] = op; tx_buf[1] = a; tx_buf[2] = d;
        spi_frame(3);
    endtask

    task automatic rd(input logic [7:0] op, input logic [7:0] a, output logic [7:0] val);
        tx_buf[0] = op; tx_buf[1] = a; tx_buf[2] = 8'h00;
        spi_frame(3);
        val = rx_buf[2];
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] r;
        RESET_N = 1'b0; sck = 1'b0; mosi = 1'b0; cs = 1'b1;
        gpa_in = 8'h00; gpb_in = 8'h00;
        wait_clks(4);
        check_val("rst_miso", {7'b0, miso}, 8'h00);
        check_val("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
        check_val("rst_inta", {7'b0, inta}, 8'h01);
        check_val("rst_gpa_out", gpa_out, 8'h00);
        check_val("rst_gpb_out", gpb_out, 8'h00);
        check_val("rst_gpa_oe", gpa_oe, 8'h00);
        check_val("rst_gpb_oe", gpb_oe, 8'h00);
        RESET_N = 1'b1;
        wait_clks(4);

        rd(8'h41, 8'h00, v);
        check_val("rd_iodira_rst", v, 8'hFF);
        check_val("rd_oe_seen", {7'b0, oe_seen}, 8'h01);
        check_val("oe_after_cs", {7'b0, miso_oe}, 8'h00);
        rd(8'h41, 8'h0A, v);
        check_val("rd_iocon_rst", v, 8'h00);

        // Basic write / output / GPIO readback
        wr(8'h40, 8'h14, 8'hA5);
        check_val("wr_gpa_out", gpa_out, 8'hA5);
        check_val("wr_oe_seen", {7'b0, oe_seen}, 8'h00);
        wr(8'h40, 8'h00, 8'h00);
        check_val("wr_gpa_oe", gpa_oe, 8'hFF);
        gpb_in = 8'h3C;
        wait_clks(4);
        tx_buf[0] = 8'h41; tx_buf[1] = 8'h12; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        spi_frame(4);
        check_val("rd_gpioa", rx_buf[2], 8'hA5);
        check_val("rd_gpiob_seq", rx_buf[3], 8'h3C);

        // Burst write and address wrap 0x15 -> 0x00
        tx_buf[0] = 8'h40; tx_buf[1] = 8'h14; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22; tx_buf[4] = 8'h33;
        spi_frame(5);
        check_val("burst_olata", gpa_out, 8'h11);
        check_val("burst_olatb", gpb_out, 8'h22);
        check_val("burst_iodira_oe", gpa_oe, 8'hCC);
        rd(8'h41, 8'h00, v);
        check_val("burst_iodira", v, 8'h33);
        tx_buf[0] = 8'h40; tx_buf[1] = 8'h15; tx_buf[2] = 8'h44; tx_buf[3] = 8'h55;
        spi_frame(4);
        check_val("wrap_olatb", gpb_out, 8'h44);
        check_val("wrap_iodira_oe", gpa_oe, 8'hAA);

        // SEQOP=1 holds the address: IODIRA=0x55, OLATA=0x11, pins 0xFF -> GPIOA = 0x55
        gpa_in = 8'hFF;
        wr(8'h40, 8'h0A, 8'h20);
        tx_buf[0] = 8'h41; tx_buf[1] = 8'h12; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
        spi_frame(5);
        check_val("seqop_b0", rx_buf[2], 8'h55);
        check_val("seqop_b1", rx_buf[3], 8'h55);
        check_val("seqop_b2", rx_buf[4], 8'h55);

        // Unimplemented address
        wr(8'h40, 8'h16, 8'hFF);
        rd(8'h41, 8'h16, v);
        check_val("rd_0x16", v, 8'h00);

        // Hardware addressing with HAEN=1, HW_ADDR=010
        wr(8'h40, 8'h0A, 8'h08);
        wr(8'h44, 8'h14, 8'h5A);
        check_val("haen_match_wr", gpa_out, 8'h5A);
        wr(8'h40, 8'h14, 8'hFF);
        check_val("haen_ignored_wr", gpa_out, 8'h5A);
        check_val("haen_ignored_oe_wr", {7'b0, oe_seen}, 8'h00);
        rd(8'h41, 8'h14, v);
        check_val("haen_ignored_oe_rd", {7'b0, oe_seen}, 8'h00);
        rd(8'h45, 8'h14, v);
        check_val("haen_match_rd", v, 8'h5A);
        wr(8'h44, 8'h0A, 8'h00);

        // Interrupt-on-change on GPA0
        wr(8'h40, 8'h00, 8'hFF);
        gpa_in = 8'h00;
        wait_clks(6);
        wr(8'h40, 8'h04, 8'h01);
        check_val("int_idle", {7'b0, inta}, 8'h01);
        @(negedge clk);
        gpa_in = 8'h01;
        repeat (3) @(posedge clk);
        #1 check_val("int_lat3", {7'b0, inta}, 8'h01);
        @(posedge clk);
        #1 check_val("int_lat4", {7'b0, inta}, 8'h00);
        rd(8'h41, 8'h0E, v);
        check_val("intfa", v, 8'h01);
        check_val("int_after_intf_rd", {7'b0, inta}, 8'h00);
        gpa_in = 8'h00;
        wait_clks(8);
        rd(8'h41, 8'h10, v);
        check_val("intcapa_held", v, 8'h01);
        check_val("int_clr_intcap", {7'b0, inta}, 8'h01);
        gpa_in = 8'h01;
        wait_clks(8);
        check_val("int_again", {7'b0, inta}, 8'h00);
        rd(8'h41, 8'h12, v);
        check_val("int_gpio_val", v, 8'h01);
        check_val("int_clr_gpio", {7'b0, inta}, 8'h01);
        rd(8'h41, 8'h0E, v);
        check_val("intfa_cleared", v, 8'h00);
        wr(8'h40, 8'h04, 8'h00);

        // Abort mid data byte, then mid opcode
        @(negedge clk);
        cs = 1'b0; #60;
        spi_bits(8'h40, 8, r);
        spi_bits(8'h14, 8, r);
        spi_bits(8'h00, 4, r);
        #60; cs = 1'b1; #120;
        check_val("abort_no_commit", gpa_out, 8'h5A);
        wr(8'h40, 8'h14, 8'hC3);
        check_val("abort_next_frame", gpa_out, 8'hC3);
        @(negedge clk);
        cs = 1'b0; #60;
        spi_bits(8'hFF, 3, r);
        #60; cs = 1'b1; #120;
        wr(8'h40, 8'h15, 8'h77);
        check_val("abort_op_next", gpb_out, 8'h77);

        // Reset mid-frame: the rest of the frame must not be decoded
        @(negedge clk);
        cs = 1'b0; #60;
        spi_bits(8'h40, 8, r);
        RESET_N = 1'b0;
        wait_clks(4);
        RESET_N = 1'b1;
        wait_clks(2);
        spi_bits(8'h40, 8, r);
        spi_bits(8'h14, 8, r);
        spi_bits(8'h99, 8, r);
        #60; cs = 1'b1; #120;
        check_val("rstmid_gpa_out", gpa_out, 8'h00);
        check_val("rstmid_gpb_out", gpb_out, 8'h00);
        wr(8'h40, 8'h14, 8'h66);
        check_val("rstmid_resume", gpa_out, 8'h66);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
